// File: rtl/gate_input_debounce.sv
// Two-channel input conditioner feeding the and_gate stage.
// Each channel: two-flop synchronizer, stability-count debounce, edge pulses.
// Channel index 0 is A, index 1 is B; channels share only clk and rst.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   STABLE  | synchronized input agrees with the output level, cnt = 0
//   PENDING | synchronized input differs, cnt = consecutive differing
//           | samples seen so far (1 .. DB_CYCLES-1)
module gate_input_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  // Terminal-count compare value: cnt + 1 == DB_CYCLES  <=>  cnt == DB_CYCLES - 1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       lvl;
  logic [1:0]       rise;
  logic [1:0]       fall;
  logic [1:0]       lvl_nxt;
  logic [1:0]       rise_nxt;
  logic [1:0]       fall_nxt;
  db_state_t        state     [2];
  db_state_t        state_nxt [2];
  logic [CNT_W-1:0] cnt       [2];
  logic [CNT_W-1:0] cnt_nxt   [2];

  assign raw = {b_raw, a_raw};

  // Two-flop synchronizer per channel, nothing between the flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce state, counter, output level and edge pulses; reset beats any pending toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= STABLE;
        cnt[ch]   <= '0;
      end
      lvl  <= 2'b00;
      rise <= 2'b00;
      fall <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= state_nxt[ch];
        cnt[ch]   <= cnt_nxt[ch];
      end
      lvl  <= lvl_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

  // Next-state logic: count consecutive differing samples, toggle on terminal count.
  always_comb begin
    lvl_nxt  = lvl;
    rise_nxt = 2'b00;
    fall_nxt = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      state_nxt[ch] = state[ch];
      cnt_nxt[ch]   = cnt[ch];
      unique case (state[ch])
        STABLE: begin
          cnt_nxt[ch] = '0;
          if (s2[ch] != lvl[ch]) begin
            if (DB_CYCLES == 1) begin
              lvl_nxt[ch]  = s2[ch];
              rise_nxt[ch] = s2[ch];
              fall_nxt[ch] = ~s2[ch];
            end else begin
              state_nxt[ch] = PENDING;
              cnt_nxt[ch]   = CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (s2[ch] == lvl[ch]) begin
            state_nxt[ch] = STABLE;
            cnt_nxt[ch]   = '0;
          end else if (cnt[ch] == CNT_LAST) begin
            state_nxt[ch] = STABLE;
            cnt_nxt[ch]   = '0;
            lvl_nxt[ch]   = s2[ch];
            rise_nxt[ch]  = s2[ch];
            fall_nxt[ch]  = ~s2[ch];
          end else begin
            cnt_nxt[ch] = cnt[ch] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[ch] = STABLE;
          cnt_nxt[ch]   = '0;
        end
      endcase
    end
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];

endmodule
